rs232_rx: RTL and testbench



---
 rtl/rs232_pkg.sv | 20 ++
 rtl/rs232_rx_sync.sv | 34 +++
 rtl/rs232_rx.sv | 145 ++++++++++++++
 tb/tb_rs232_rx.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/rs232_pkg.sv
// Shared definitions for the RS232 receive path.
//   rx_state_e : receiver FSM states
//   DATA_BITS  : payload bits per frame (8N1)
//   maj3       : 2-of-3 majority vote used for bit decisions
package rs232_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam int unsigned DATA_BITS = 8;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/rs232_rx_sync.sv
// Brings the asynchronous serial line into the i_clk domain.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_rx         : raw serial line (idle high)
//   rx_s         : synchronized line
//   fall         : one-cycle 1->0 transition strobe on rx_s
// All flops reset to 1 so an idle line produces no spurious edge.
module rs232_rx_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_rx,
  output logic rx_s,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic dly_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      dly_q  <= 1'b1;
    end else begin
      meta_q <= i_rx;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  assign rx_s = sync_q;
  assign fall = dly_q & ~sync_q;

endmodule

// File: rtl/rs232_rx.sv
// 8N1 UART receiver with 3-sample majority voting around mid-bit.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_rx         : serial line, idle high, asynchronous to i_clk
//   o_data       : last good byte, held until the next good byte
//   o_rx_done    : one-cycle pulse when o_data is updated
//   o_frame_err  : one-cycle pulse when the stop bit is sampled low
//   o_busy       : high while a frame is in progress
module rs232_rx
  import rs232_pkg::*;
#(
  parameter logic [14:0] BPS_CNT_MAX = 15'd2604
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_rx_done,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam logic [14:0] MID = BPS_CNT_MAX / 15'd2;

  logic rx_s;
  logic fall;

  rs232_rx_sync u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_rx  (i_rx),
    .rx_s  (rx_s),
    .fall  (fall)
  );

  rx_state_e   state_q,   state_d;
  logic [14:0] bps_cnt_q, bps_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q,   shift_d;
  logic        samp_a_q,  samp_a_d;
  logic        samp_b_q,  samp_b_d;
  logic [7:0]  data_q,    data_d;
  logic        done_q,    done_d;
  logic        err_q,     err_d;
  logic        busy_q,    busy_d;

  logic decide;
  logic bit_end;
  logic maj;

  always_comb begin
    state_d   = state_q;
    bps_cnt_d = bps_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    samp_a_d  = samp_a_q;
    samp_b_d  = samp_b_q;
    data_d    = data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    decide  = (bps_cnt_q == MID + 15'd1);
    bit_end = (bps_cnt_q == BPS_CNT_MAX - 15'd1);
    // Third vote is the live MID+1 sample, so the decision needs no extra cycle.
    maj     = maj3(samp_a_q, samp_b_q, rx_s);

    if (state_q == IDLE) begin
      bps_cnt_d = '0;
    end else begin
      bps_cnt_d = bit_end ? '0 : bps_cnt_q + 15'd1;
    end

    if (bps_cnt_q == MID - 15'd1) samp_a_d = rx_s;
    if (bps_cnt_q == MID)         samp_b_d = rx_s;

    case (state_q)
      IDLE: begin
        if (fall) state_d = START;
      end
      START: begin
        if (decide && maj) begin
          state_d   = IDLE;
          bps_cnt_d = '0;
        end else if (bit_end) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (decide) shift_d[bit_idx_q] = maj;
        if (bit_end) begin
          if (bit_idx_q == 3'(DATA_BITS - 1)) state_d = STOP;
          else                                bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      STOP: begin
        // Leave at the decision point so a back-to-back start bit is caught.
        if (decide) begin
          state_d   = IDLE;
          bps_cnt_d = '0;
          if (maj) begin
            data_d = shift_q;
            done_d = 1'b1;
          end else begin
            err_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      bps_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      samp_a_q  <= 1'b0;
      samp_b_q  <= 1'b0;
      data_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bps_cnt_q <= bps_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      samp_a_q  <= samp_a_d;
      samp_b_q  <= samp_b_d;
      data_q    <= data_d;
      done_q    <= done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign o_data      = data_q;
  assign o_rx_done   = done_q;
  assign o_frame_err = err_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_rs232_rx.sv
module tb_rs232_rx;

  localparam int unsigned BPS  = 8;
  localparam int unsigned MID  = BPS / 2;
  localparam int unsigned FULL = 10 * BPS;

  logic       clk;
  logic       i_rst;
  logic       i_rx;
  logic [7:0] o_data;
  logic       o_rx_done;
  logic       o_frame_err;
  logic       o_busy;

  rs232_rx #(.BPS_CNT_MAX(15'd8)) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_rx        (i_rx),
    .o_data      (o_data),
    .o_rx_done   (o_rx_done),
    .o_frame_err (o_frame_err),
    .o_busy      (o_busy)
  );

  typedef struct {
    logic        err;
    logic [7:0]  data;
    int unsigned cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  last_good;
  int unsigned cyc;
  int unsigned passed;
  int unsigned total;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every output pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    if (o_rx_done || o_frame_err) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'(exp_q.size()), 32'd1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_err",   32'(o_frame_err), 32'(e.err));
        check("pulse_done",  32'(o_rx_done),   32'(!e.err));
        check("pulse_data",  32'(o_data),      32'(e.data));
        check("pulse_cycle", cyc,              e.cyc);
      end
    end
  end

  // Drives one frame; with limit < FULL the frame is cut short.
  task automatic send_frame(input logic [7:0] data, input logic stop,
                            input logic glitch, input int unsigned limit,
                            input logic expect_it);
    int unsigned sent;
    logic v;
    sent = 0;
    for (int b = 0; b < 10; b++) begin
      if (b == 0)      v = 1'b0;
      else if (b == 9) v = stop;
      else             v = data[b-1];
      for (int c = 0; c < int'(BPS); c++) begin
        if (sent == limit) return;
        @(posedge clk);
        #1;
        if (b == 0 && c == 0 && expect_it) begin
          exp_t e;
          e.err  = ~stop;
          e.data = stop ? data : last_good;
          // start enters START 3 edges after drive; done visible after decision edge
          e.cyc  = cyc + 3 + 9 * BPS + MID + 2;
          exp_q.push_back(e);
          if (stop) last_good = data;
        end
        // bit 3 sits in b==4; offset MID+1 on the line lands on the MID sample
        i_rx = v ^ (glitch && b == 4 && c == int'(MID) + 1);
        sent++;
      end
    end
  endtask

  task automatic idle_checks(input string tag, input logic [7:0] data);
    repeat (6) @(posedge clk);
    #1;
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_data"}, 32'(o_data), 32'(data));
  endtask

  initial begin
    passed    = 0;
    total     = 0;
    last_good = 8'h00;
    i_rst     = 1'b1;
    i_rx      = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", 32'(o_data),      32'd0);
    check("rst_done", 32'(o_rx_done),   32'd0);
    check("rst_err",  32'(o_frame_err), 32'd0);
    check("rst_busy", 32'(o_busy),      32'd0);
    i_rst = 1'b0;
    repeat (3) @(posedge clk);

    // 1: good frame
    send_frame(8'hA5, 1'b1, 1'b0, FULL, 1'b1);
    idle_checks("t1", 8'hA5);

    // 2: false start
    @(posedge clk); #1 i_rx = 1'b0;
    repeat (2) @(posedge clk);
    #1 i_rx = 1'b1;
    @(posedge clk); #1;
    check("t2_busy_start", 32'(o_busy), 32'd1);
    repeat (10) @(posedge clk);
    #1;
    check("t2_busy_end", 32'(o_busy), 32'd0);
    check("t2_data",     32'(o_data), 32'hA5);

    // 3: bad stop bit, line left low
    send_frame(8'h3C, 1'b0, 1'b0, FULL, 1'b1);
    for (int k = 0; k < 4; k++) begin
      repeat (10) @(posedge clk);
      #1;
      check("t3_low_idle", 32'(o_busy), 32'd0);
    end
    check("t3_data", 32'(o_data), 32'hA5);
    i_rx = 1'b1;
    repeat (5) @(posedge clk);

    // 4: back-to-back frames
    send_frame(8'h00, 1'b1, 1'b0, FULL, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b0, FULL, 1'b1);
    idle_checks("t4", 8'hFF);

    // 5: glitch on bit 3 rejected by majority
    send_frame(8'h55, 1'b1, 1'b1, FULL, 1'b1);
    idle_checks("t5", 8'h55);

    // 6: reset in the middle of a frame
    send_frame(8'h81, 1'b1, 1'b0, 40, 1'b0);
    check("t6_busy_pre", 32'(o_busy), 32'd1);
    i_rx = 1'b1;
    #3 i_rst = 1'b1;
    #1;
    check("t6_rst_busy", 32'(o_busy),      32'd0);
    check("t6_rst_data", 32'(o_data),      32'd0);
    check("t6_rst_done", 32'(o_rx_done),   32'd0);
    check("t6_rst_err",  32'(o_frame_err), 32'd0);
    last_good = 8'h00;
    repeat (3) @(posedge clk);
    #1 i_rst = 1'b0;
    repeat (3) @(posedge clk);
    send_frame(8'h7E, 1'b1, 1'b0, FULL, 1'b1);
    idle_checks("t6", 8'h7E);

    repeat (20) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
